// File: rtl/cost_table_server.sv
// Cost-table responder for the assignment-search engine: loads an 8x8 cost table,
// answers (W,J) lookups combinationally, and audits the query stream and final result.
module cost_table_server #(
  parameter int N_PERM = 40320
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load_valid,
  input  logic [6:0] load_data,
  output logic       load_ready,
  output logic       table_ready,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  input  logic       Valid,
  input  logic [9:0] MinCost,
  input  logic [3:0] MatchCount,
  output logic       res_valid,
  output logic       res_ok,
  output logic [9:0] res_min_cost,
  output logic [3:0] res_match_count,
  output logic [15:0] perm_count,
  output logic       perm_err
);

  localparam logic [15:0] N_PERM_W = 16'(N_PERM);

  typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [2:0]  exp_q, exp_d;
  logic [7:0]  mask_q, mask_d;
  logic [9:0]  sum_q, sum_d;
  logic [9:0]  ref_min_q, ref_min_d;
  logic [3:0]  ref_cnt_q, ref_cnt_d;
  logic [15:0] perm_count_q, perm_count_d;
  logic        perm_err_q, perm_err_d;
  logic        load_ready_q, load_ready_d;
  logic        table_ready_q, table_ready_d;
  logic        res_valid_q, res_valid_d;
  logic        res_ok_q, res_ok_d;
  logic [9:0]  res_min_cost_q, res_min_cost_d;
  logic [3:0]  res_match_count_q, res_match_count_d;

  logic [6:0]  mem [0:63];
  logic        accept;
  logic        group_done;
  logic [9:0]  total;
  logic [7:0]  j_onehot;

  assign accept   = load_valid && load_ready_q;
  assign Cost     = table_ready_q ? mem[{W, J}] : 7'd0;
  assign j_onehot = 8'b1 << J;
  assign total    = sum_q + {3'b000, Cost};

  // Table storage is deliberately not reset; it only becomes meaningful once fully loaded.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[addr_q] <= load_data;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    exp_d             = exp_q;
    mask_d            = mask_q;
    sum_d             = sum_q;
    ref_min_d         = ref_min_q;
    ref_cnt_d         = ref_cnt_q;
    perm_count_d      = perm_count_q;
    perm_err_d        = perm_err_q;
    load_ready_d      = load_ready_q;
    table_ready_d     = table_ready_q;
    res_valid_d       = 1'b0;
    res_ok_d          = res_ok_q;
    res_min_cost_d    = res_min_cost_q;
    res_match_count_d = res_match_count_q;
    group_done        = 1'b0;

    // Outside SERVE the monitor sits in its cleared state, ready for the next run.
    if (state_q != SERVE) begin
      exp_d        = 3'd0;
      mask_d       = 8'd0;
      sum_d        = 10'd0;
      ref_min_d    = 10'd1023;
      ref_cnt_d    = 4'd0;
      perm_count_d = 16'd0;
      perm_err_d   = 1'b0;
    end

    case (state_q)
      LOAD: begin
        if (accept) begin
          addr_d = addr_q + 6'd1;
          if (addr_q == 6'd63) begin
            state_d       = SERVE;
            load_ready_d  = 1'b0;
            table_ready_d = 1'b1;
          end
        end
      end

      SERVE: begin
        if (W == 3'd0) begin
          mask_d = j_onehot;
          sum_d  = {3'b000, Cost};
          exp_d  = 3'd1;
        end else if ((W == exp_q) && (exp_q != 3'd0)) begin
          if (mask_q[J]) begin
            perm_err_d = 1'b1;
          end else begin
            mask_d = mask_q | j_onehot;
            sum_d  = total;
          end
          if (exp_q == 3'd7) begin
            group_done = 1'b1;
            exp_d      = 3'd0;
          end else begin
            exp_d = exp_q + 3'd1;
          end
        end else begin
          perm_err_d = 1'b1;
          exp_d      = 3'd0;
        end

        if (group_done) begin
          if (perm_count_q != 16'hFFFF) begin
            perm_count_d = perm_count_q + 16'd1;
          end
          if (total < ref_min_q) begin
            ref_min_d = total;
            ref_cnt_d = 4'd1;
          end else if (total == ref_min_q) begin
            ref_cnt_d = ref_cnt_q + 4'd1;
          end
        end

        // Verdict uses next-state monitor values so a group closing on the Valid cycle counts.
        if (Valid) begin
          res_min_cost_d    = MinCost;
          res_match_count_d = MatchCount;
          res_ok_d          = (MinCost == ref_min_d) && (MatchCount == ref_cnt_d) &&
                              !perm_err_d && (perm_count_d == N_PERM_W);
          res_valid_d       = 1'b1;
          state_d           = DONE;
          table_ready_d     = 1'b0;
        end
      end

      DONE: begin
        state_d      = LOAD;
        load_ready_d = 1'b1;
        addr_d       = 6'd0;
      end

      default: begin
        state_d       = LOAD;
        load_ready_d  = 1'b1;
        table_ready_d = 1'b0;
        addr_d        = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= LOAD;
      addr_q            <= 6'd0;
      exp_q             <= 3'd0;
      mask_q            <= 8'd0;
      sum_q             <= 10'd0;
      ref_min_q         <= 10'd1023;
      ref_cnt_q         <= 4'd0;
      perm_count_q      <= 16'd0;
      perm_err_q        <= 1'b0;
      load_ready_q      <= 1'b1;
      table_ready_q     <= 1'b0;
      res_valid_q       <= 1'b0;
      res_ok_q          <= 1'b0;
      res_min_cost_q    <= 10'd0;
      res_match_count_q <= 4'd0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      exp_q             <= exp_d;
      mask_q            <= mask_d;
      sum_q             <= sum_d;
      ref_min_q         <= ref_min_d;
      ref_cnt_q         <= ref_cnt_d;
      perm_count_q      <= perm_count_d;
      perm_err_q        <= perm_err_d;
      load_ready_q      <= load_ready_d;
      table_ready_q     <= table_ready_d;
      res_valid_q       <= res_valid_d;
      res_ok_q          <= res_ok_d;
      res_min_cost_q    <= res_min_cost_d;
      res_match_count_q <= res_match_count_d;
    end
  end

  assign load_ready      = load_ready_q;
  assign table_ready     = table_ready_q;
  assign res_valid       = res_valid_q;
  assign res_ok          = res_ok_q;
  assign res_min_cost    = res_min_cost_q;
  assign res_match_count = res_match_count_q;
  assign perm_count      = perm_count_q;
  assign perm_err        = perm_err_q;

endmodule

// File: tb/tb_cost_table_server.sv
// Scoreboard bench for cost_table_server: table loads, lookups, permutation monitor
// and end-of-run result verdicts on a reduced permutation count.
module tb_cost_table_server;

  localparam int NP = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_valid = 1'b0;
  logic [6:0]  load_data = 7'd0;
  logic [2:0]  W = 3'd0;
  logic [2:0]  J = 3'd0;
  logic        Valid = 1'b0;
  logic [9:0]  MinCost = 10'd0;
  logic [3:0]  MatchCount = 4'd0;
  logic        load_ready, table_ready, res_valid, res_ok, perm_err;
  logic [6:0]  Cost;
  logic [9:0]  res_min_cost;
  logic [3:0]  res_match_count;
  logic [15:0] perm_count;

  cost_table_server #(.N_PERM(NP)) dut (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .table_ready(table_ready), .W(W), .J(J), .Cost(Cost),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount), .res_valid(res_valid),
    .res_ok(res_ok), .res_min_cost(res_min_cost), .res_match_count(res_match_count),
    .perm_count(perm_count), .perm_err(perm_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ok;
    logic [9:0] min;
    logic [3:0] cnt;
  } res_t;

  int         checks = 0;
  int         passes = 0;
  logic [6:0] tb_mem [64];
  bit         tb_serving = 1'b0;
  logic [6:0] cost_sb [$];
  res_t       res_sb [$];
  logic [6:0] exp_cost;
  res_t       exp_res;

  // Scoreboard side: lookups are sampled mid-cycle, results whenever res_valid is seen.
  always @(negedge CLK) begin
    #2;
    if (cost_sb.size() > 0) begin
      exp_cost = cost_sb.pop_front();
      checks++;
      if (Cost !== exp_cost) $display("[TB] FAIL cost W=%0d J=%0d: got %0d expected %0d", W, J, Cost, exp_cost);
      else passes++;
    end
    if (res_valid === 1'b1) begin
      if (res_sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_res_valid: got 1 expected 0");
      end else begin
        exp_res = res_sb.pop_front();
        checks++;
        if (res_ok !== exp_res.ok) $display("[TB] FAIL res_ok: got %0d expected %0d", res_ok, exp_res.ok);
        else passes++;
        checks++;
        if (res_min_cost !== exp_res.min) $display("[TB] FAIL res_min_cost: got %0d expected %0d", res_min_cost, exp_res.min);
        else passes++;
        checks++;
        if (res_match_count !== exp_res.cnt) $display("[TB] FAIL res_match_count: got %0d expected %0d", res_match_count, exp_res.cnt);
        else passes++;
      end
    end
  end

  function automatic logic [6:0] table_value(input int kind, input logic [5:0] idx);
    case (kind)
      0:       return (idx[5:3] == idx[2:0]) ? 7'd0 : 7'd10;
      1:       return 7'(idx[5:3]) + 7'(idx[2:0]);
      2:       return 7'd3;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic drive_query(input logic [2:0] w, input logic [2:0] j);
    @(negedge CLK);
    Valid = 1'b0;
    W = w;
    J = j;
    cost_sb.push_back(tb_serving ? tb_mem[{w, j}] : 7'd0);
  endtask

  task automatic load_beat(input logic [6:0] d, input int idx);
    @(negedge CLK);
    load_valid = 1'b1;
    load_data = d;
    tb_mem[idx] = d;
  endtask

  task automatic end_load();
    @(negedge CLK);
    load_valid = 1'b0;
    tb_serving = 1'b1;
  endtask

  task automatic load_table(input int kind);
    for (int i = 0; i < 64; i++) load_beat(table_value(kind, 6'(i)), i);
    end_load();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    load_valid = 1'b0;
    Valid = 1'b0;
    W = 3'd0;
    J = 3'd0;
    tb_serving = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reset_load_ready: got %0d expected 1", load_ready); else passes++;
    checks++; if (table_ready !== 1'b0) $display("[TB] FAIL reset_table_ready: got %0d expected 0", table_ready); else passes++;
    checks++; if (Cost !== 7'd0) $display("[TB] FAIL reset_cost: got %0d expected 0", Cost); else passes++;
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %0d expected 0", res_valid); else passes++;
    checks++; if (res_ok !== 1'b0) $display("[TB] FAIL reset_res_ok: got %0d expected 0", res_ok); else passes++;
    checks++; if (res_min_cost !== 10'd0) $display("[TB] FAIL reset_res_min_cost: got %0d expected 0", res_min_cost); else passes++;
    checks++; if (res_match_count !== 4'd0) $display("[TB] FAIL reset_res_match_count: got %0d expected 0", res_match_count); else passes++;
    checks++; if (perm_count !== 16'd0) $display("[TB] FAIL reset_perm_count: got %0d expected 0", perm_count); else passes++;
    checks++; if (perm_err !== 1'b0) $display("[TB] FAIL reset_perm_err: got %0d expected 0", perm_err); else passes++;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 30; i++) load_beat(7'($urandom_range(0, 127)), i);
    @(negedge CLK);
    load_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (load_ready !== 1'b1) $display("[TB] FAIL midload_load_ready: got %0d expected 1", load_ready); else passes++;
    for (int i = 0; i < 64; i++) load_beat(table_value(0, 6'(i)), i);
    checks++; if (table_ready !== 1'b0) $display("[TB] FAIL midload_early_ready: got %0d expected 0", table_ready); else passes++;
    end_load();
    checks++; if (table_ready !== 1'b1) $display("[TB] FAIL midload_table_ready: got %0d expected 1", table_ready); else passes++;
    checks++; if (load_ready !== 1'b0) $display("[TB] FAIL midload_load_ready_serve: got %0d expected 0", load_ready); else passes++;
    drive_query(3'd3, 3'd3);
    drive_query(3'd3, 3'd4);
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    load_valid = 1'b1;
    load_data = 7'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++; if (load_ready !== 1'b0) $display("[TB] FAIL backpressure_load_ready: got %0d expected 0", load_ready); else passes++;
    end
    for (int i = 0; i < 64; i++) drive_query(3'(i / 8), 3'(i % 8));
    @(negedge CLK);
    load_valid = 1'b0;
  endtask

  task automatic test_legal_group();
    do_reset();
    load_table(1);
    for (int w = 0; w < 8; w++) drive_query(3'(w), 3'(7 - w));
    checks++; if (perm_count !== 16'd0) $display("[TB] FAIL legal_count_early: got %0d expected 0", perm_count); else passes++;
    drive_query(3'd0, 3'd0);
    checks++; if (perm_count !== 16'd1) $display("[TB] FAIL legal_perm_count: got %0d expected 1", perm_count); else passes++;
    checks++; if (perm_err !== 1'b0) $display("[TB] FAIL legal_perm_err: got %0d expected 0", perm_err); else passes++;
  endtask

  task automatic test_duplicate();
    int js[8];
    js = '{0, 1, 2, 2, 4, 5, 6, 7};
    for (int w = 0; w < 8; w++) begin
      drive_query(3'(w), 3'(js[w]));
      if (w == 3) begin
        checks++; if (perm_err !== 1'b0) $display("[TB] FAIL dup_err_early: got %0d expected 0", perm_err); else passes++;
      end
      if (w == 4) begin
        checks++; if (perm_err !== 1'b1) $display("[TB] FAIL dup_err: got %0d expected 1", perm_err); else passes++;
      end
    end
    drive_query(3'd0, 3'd0);
    checks++; if (perm_count !== 16'd2) $display("[TB] FAIL dup_perm_count: got %0d expected 2", perm_count); else passes++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    load_table(1);
    for (int w = 0; w < 4; w++) drive_query(3'(w), 3'(w));
    drive_query(3'd5, 3'd5);
    checks++; if (perm_err !== 1'b0) $display("[TB] FAIL ooo_err_early: got %0d expected 0", perm_err); else passes++;
    for (int w = 4; w < 8; w++) drive_query(3'(w), 3'(w));
    drive_query(3'd0, 3'd0);
    checks++; if (perm_err !== 1'b1) $display("[TB] FAIL ooo_perm_err: got %0d expected 1", perm_err); else passes++;
    checks++; if (perm_count !== 16'd0) $display("[TB] FAIL ooo_perm_count: got %0d expected 0", perm_count); else passes++;
  endtask

  // Feeds ngroups legal permutations, Valid riding on the final query of the last group.
  task automatic run_full(input int kind, input int ngroups, input int delta);
    int         p[8];
    int         total, model_min, model_cnt, tmp, r;
    logic [9:0] rep_min;
    logic [3:0] rep_cnt;
    logic       exp_ok;
    res_t       e;
    load_table(kind);
    model_min = 1023;
    model_cnt = 0;
    for (int g = 0; g < ngroups; g++) begin
      for (int k = 0; k < 8; k++) p[k] = k;
      if (g != 0) begin
        for (int k = 7; k > 0; k--) begin
          r = int'($urandom_range(0, k));
          tmp = p[k]; p[k] = p[r]; p[r] = tmp;
        end
      end
      total = 0;
      for (int k = 0; k < 8; k++) total += int'(tb_mem[k * 8 + p[k]]);
      if (total < model_min) begin
        model_min = total;
        model_cnt = 1;
      end else if (total == model_min) begin
        model_cnt++;
      end
      for (int w = 0; w < 8; w++) begin
        if (g == ngroups - 1 && w == 7) begin
          rep_min = 10'(model_min + delta);
          rep_cnt = 4'(model_cnt);
          exp_ok = (rep_min == 10'(model_min)) && (rep_cnt == 4'(model_cnt % 16)) && (ngroups == NP);
          @(negedge CLK);
          W = 3'd7;
          J = 3'(p[7]);
          Valid = 1'b1;
          MinCost = rep_min;
          MatchCount = rep_cnt;
          cost_sb.push_back(tb_mem[{3'd7, 3'(p[7])}]);
          e.ok = exp_ok; e.min = rep_min; e.cnt = rep_cnt;
          res_sb.push_back(e);
        end else begin
          drive_query(3'(w), 3'(p[w]));
        end
      end
    end
    @(negedge CLK);
    Valid = 1'b0;
    W = 3'd0;
    J = 3'd0;
    tb_serving = 1'b0;
    checks++; if (table_ready !== 1'b0) $display("[TB] FAIL done_table_ready: got %0d expected 0", table_ready); else passes++;
    checks++; if (perm_count !== 16'(ngroups)) $display("[TB] FAIL done_perm_count: got %0d expected %0d", perm_count, ngroups); else passes++;
    @(negedge CLK);
    checks++; if (res_sb.size() != 0) $display("[TB] FAIL res_timeout: got %0d pending expected 0", res_sb.size()); else passes++;
    res_sb.delete();
    checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reload_load_ready: got %0d expected 1", load_ready); else passes++;
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL res_valid_pulse: got %0d expected 0", res_valid); else passes++;
    checks++; if (perm_count !== 16'd0) $display("[TB] FAIL reload_perm_count: got %0d expected 0", perm_count); else passes++;
    checks++; if (res_ok !== exp_ok) $display("[TB] FAIL held_res_ok: got %0d expected %0d", res_ok, exp_ok); else passes++;
    checks++; if (res_min_cost !== rep_min) $display("[TB] FAIL held_res_min_cost: got %0d expected %0d", res_min_cost, rep_min); else passes++;
  endtask

  task automatic test_full_run();
    do_reset();
    run_full(0, NP, 0);
    run_full(0, NP, 1);
  endtask

  task automatic test_match_wrap();
    run_full(2, NP, 0);
  endtask

  task automatic test_short_run();
    run_full(3, NP - 1, 0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_backpressure();
    test_legal_group();
    test_duplicate();
    test_out_of_order();
    test_full_run();
    test_match_wrap();
    test_short_run();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cost_table_server.md
Name: cost_table_server

Overview:
- Responder side of the worker/job cost-query interface used by the assignment-search engine.
- Holds an 8x8 table of 7-bit costs, loaded over a valid/ready stream, and answers (W,J) queries combinationally with Cost.
- Passively monitors the query stream: checks each 8-query group is a legal permutation and computes its own min-cost/match-count reference.
- Checks the engine's reported result when Valid pulses; serves as the on-chip scoreboard/table for the assignment engine.

Parameters:
- N_PERM, 40320, expected number of complete permutation groups per run (8!).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- load_valid  input  1  load beat present.
- load_data  input  7  cost value; beats row-major, index = W*8+J.
- load_ready  output  1  high in LOAD state only.
- table_ready  output  1  high in SERVE state.
- W  input  3  queried worker.
- J  input  3  queried job.
- Cost  output  7  table[{W,J}] combinationally in SERVE; 0 otherwise.
- Valid  input  1  engine done pulse.
- MinCost  input  10  engine-reported minimum.
- MatchCount  input  4  engine-reported match count.
- res_valid  output  1  one-cycle pulse: result latched.
- res_ok  output  1  comparison verdict; valid while res_valid=1, held afterwards.
- res_min_cost  output  10  latched MinCost.
- res_match_count  output  4  latched MatchCount.
- perm_count  output  16  completed groups this run.
- perm_err  output  1  sticky protocol error.

Behaviour:
- States: LOAD, SERVE, DONE. Reset state is LOAD.
- Reset values:
  - load_ready=1, table_ready=0, Cost=0, res_valid=0, res_ok=0.
  - res_min_cost=0, res_match_count=0, perm_count=0, perm_err=0.
  - Internal: addr=0, exp=0, mask=0, sum=0, ref_min=1023, ref_cnt=0.
  - Table RAM is not reset; contents are undefined until loaded.
- LOAD:
  - A beat is accepted when load_valid && load_ready. On accept, write mem[addr] and increment addr.
  - The beat accepted with addr=63 moves the block to SERVE next cycle; addr wraps to 0.
  - In LOAD, Valid is ignored and the monitor is held cleared.
- SERVE:
  - load_ready=0; load_valid is ignored and never accepted.
  - Cost = mem[{W,J}] with zero-cycle latency.
- Monitor (SERVE only), evaluated every cycle in this priority order:
  1. W==0: restart the group. mask=onehot(J), sum=Cost, exp=1. Repeated idle W=0,J=0 cycles are legal.
  2. W==exp, exp!=0:
     - If mask[J] is already set, set perm_err.
     - Otherwise mask|=onehot(J) and sum+=Cost.
     - If exp==7, the group completes: total=sum+Cost (10-bit, max 1016), perm_count++, exp=0.
     - Else exp++.
  3. Otherwise (W!=0, W!=exp): set perm_err and set exp=0.
- Group completion updates the reference:
  - total<ref_min: ref_min=total, ref_cnt=1.
  - total==ref_min: ref_cnt=ref_cnt+1, wrapping mod 16 to match the 4-bit report.
  - Otherwise: no change.
- perm_count saturates at 65535. perm_err stays set until LOAD is re-entered or RST.
- Valid=1 in SERVE:
  - Latch MinCost/MatchCount into res_min_cost/res_match_count; pulse res_valid next cycle.
  - res_ok = (MinCost==ref_min) && (MatchCount==ref_cnt) && !perm_err && (perm_count==N_PERM).
  - The comparison includes any group completing in the same cycle.
  - Go to DONE.
- DONE: outputs held. The next cycle goes to LOAD, clearing the monitor and addr; res_* hold until the next res_valid.
- RST asserted mid-load or mid-serve: all state returns to reset values immediately; a partial load is discarded.

Test Plan:
- Reset mid-load: load 30 beats, pulse RST, then load 64 beats of (w==j)?0:10 -> addr restarts, table_ready rises the cycle after beat 64; W=3,J=3 gives Cost=0; W=3,J=4 gives Cost=10.
- Backpressure: hold load_valid=1 with data=5 after the table is full -> load_ready=0 in SERVE, no writes; all Cost=cost pattern unchanged.
- Legal group: drive W=0..7 with J=7,6,5,4,3,2,1,0 on a table where cost=w+j -> perm_count=1, ref_min=56, ref_cnt=1, perm_err=0.
- Duplicate job: drive W=0..7 with J=0,1,2,2,4,5,6,7 -> perm_err=1 at the 4th query; perm_count increments after the group still completes.
- Out-of-order worker: drive W=0,1,2,3 then W=5 -> perm_err=1, exp=0.
- Full run with the real engine on the diagonal table -> Valid pulse, res_min_cost=0, res_match_count=1, perm_count=40320, res_ok=1. Corrupting MinCost by +1 at Valid gives res_ok=0.
